// File: rtl/pwconv_pe_mlane.sv
// pwconv_pe_mlane: multi-lane pointwise-convolution processing element.
// Each beat multiplies LANES signed pixel/weight pairs. The products are
// summed, and the sums are accumulated over one reduction group. Bias is
// loaded on the first beat of a group. The accumulator saturates with a
// sticky flag. Optional ReLU is applied when the result is emitted.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           synchronous clear of pipeline and accumulator
//   in_valid        beat valid
//   in_last         beat is last of its group
//   pixel_i         packed signed pixels, lane k = [k*DATA_W +: DATA_W]
//   weight_i        packed signed weights, same lane order
//   bias_i          signed bias, used on the first beat of a group
//   relu_en         sampled with the last beat; clamps a negative result to 0
//   result_o        signed group result (holds until the next out_valid)
//   out_valid       one-cycle pulse marking a new result_o/sat_o
//   sat_o           some accumulate step of the group saturated
//   busy_o          group open or beats in flight
module pwconv_pe_mlane #(
    parameter  int DATA_W   = 8,
    parameter  int FILTER_W = 8,
    parameter  int BIAS_W   = 16,
    parameter  int LANES    = 4,
    parameter  int GUARD_W  = 6,
    localparam int ACC_W    = DATA_W + FILTER_W + $clog2(LANES) + GUARD_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [LANES*DATA_W-1:0]      pixel_i,
    input  logic [LANES*FILTER_W-1:0]    weight_i,
    input  logic [BIAS_W-1:0]            bias_i,
    input  logic                         relu_en,
    output logic [ACC_W-1:0]             result_o,
    output logic                         out_valid,
    output logic                         sat_o,
    output logic                         busy_o
);

    localparam int PROD_W = DATA_W + FILTER_W;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OPEN = 1'b1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                       state_q, state_d;

    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_last_q, s1_last_d;
    logic                       s1_first_q, s1_first_d;
    logic                       s1_relu_q, s1_relu_d;
    logic signed [BIAS_W-1:0]   s1_bias_q, s1_bias_d;
    logic signed [PROD_W-1:0]   s1_prod_q [LANES];
    logic signed [PROD_W-1:0]   s1_prod_d [LANES];

    logic                       s2_valid_q, s2_valid_d;
    logic                       s2_last_q, s2_last_d;
    logic                       s2_first_q, s2_first_d;
    logic                       s2_relu_q, s2_relu_d;
    logic signed [BIAS_W-1:0]   s2_bias_q, s2_bias_d;
    logic signed [ACC_W-1:0]    s2_sum_q, s2_sum_d;

    logic                       s3_valid_q, s3_valid_d;
    logic                       s3_last_q, s3_last_d;
    logic                       s3_relu_q, s3_relu_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       sat_q, sat_d;

    logic                       out_valid_q, out_valid_d;
    logic [ACC_W-1:0]           result_q, result_d;
    logic                       osat_q, osat_d;

    logic                       accept;
    logic signed [ACC_W-1:0]    base_c;
    logic signed [ACC_W:0]      wide_c;
    logic                       ovf_c;

    assign accept = in_valid & ~flush;

    always_comb begin
        state_d     = state_q;
        s1_valid_d  = accept;
        s1_last_d   = s1_last_q;
        s1_first_d  = s1_first_q;
        s1_relu_d   = s1_relu_q;
        s1_bias_d   = s1_bias_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s1_valid_q;
        s2_last_d   = s1_last_q;
        s2_first_d  = s1_first_q;
        s2_relu_d   = s1_relu_q;
        s2_bias_d   = s1_bias_q;
        s2_sum_d    = s2_sum_q;
        s3_valid_d  = s2_valid_q;
        s3_last_d   = s2_last_q;
        s3_relu_d   = s2_relu_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = s3_valid_q & s3_last_q;
        result_d    = result_q;
        osat_d      = osat_q;
        base_c      = '0;
        wide_c      = '0;
        ovf_c       = 1'b0;

        // S1: per-lane products; a beat accepted while IDLE opens a group.
        if (accept) begin
            s1_last_d  = in_last;
            s1_first_d = (state_q == ST_IDLE);
            s1_relu_d  = relu_en;
            s1_bias_d  = bias_i;
            for (int unsigned k = 0; k < LANES; k++) begin
                s1_prod_d[k] = $signed(pixel_i[k*DATA_W +: DATA_W]) *
                               $signed(weight_i[k*FILTER_W +: FILTER_W]);
            end
            state_d = in_last ? ST_IDLE : ST_OPEN;
        end

        // S2: exact sum of products, sign-extended to the accumulator width.
        if (s1_valid_q) begin
            s2_sum_d = '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                s2_sum_d = s2_sum_d + ACC_W'(s1_prod_q[k]);
            end
        end

        // S3: the first beat loads bias+sum, so back-to-back groups never mix.
        if (s2_valid_q) begin
            base_c = s2_first_q ? ACC_W'(s2_bias_q) : acc_q;
            wide_c = {base_c[ACC_W-1], base_c} + {s2_sum_q[ACC_W-1], s2_sum_q};
            ovf_c  = wide_c[ACC_W] ^ wide_c[ACC_W-1];
            acc_d  = ovf_c ? (wide_c[ACC_W] ? ACC_MIN : ACC_MAX) : wide_c[ACC_W-1:0];
            sat_d  = (s2_first_q ? 1'b0 : sat_q) | ovf_c;
        end

        // The output register samples acc_q before the next group's first beat
        // overwrites it on the same edge.
        if (s3_valid_q && s3_last_q) begin
            result_d = (s3_relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
            osat_d   = sat_q;
        end

        if (flush) begin
            state_d     = ST_IDLE;
            s2_valid_d  = 1'b0;
            s3_valid_d  = 1'b0;
            acc_d       = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
            result_d    = result_q;
            osat_d      = osat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_relu_q   <= 1'b0;
            s1_bias_q   <= '0;
            s1_prod_q   <= '{default: '0};
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_relu_q   <= 1'b0;
            s2_bias_q   <= '0;
            s2_sum_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_relu_q   <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            osat_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_first_q  <= s1_first_d;
            s1_relu_q   <= s1_relu_d;
            s1_bias_q   <= s1_bias_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_first_q  <= s2_first_d;
            s2_relu_q   <= s2_relu_d;
            s2_bias_q   <= s2_bias_d;
            s2_sum_q    <= s2_sum_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            s3_relu_q   <= s3_relu_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            osat_q      <= osat_d;
        end
    end

    assign result_o  = result_q;
    assign out_valid = out_valid_q;
    assign sat_o     = osat_q;
    assign busy_o    = (state_q == ST_OPEN) | s1_valid_q | s2_valid_q |
                       s3_valid_q | out_valid_q;

endmodule

// File: tb/tb_pwconv_pe_mlane.sv
// tb_pwconv_pe_mlane: self-checking bench for pwconv_pe_mlane (default parameters).
// A group-level reference model tracks accumulator, sticky saturation and the
// time each result is due. A negedge monitor compares every cycle's outputs.
module tb_pwconv_pe_mlane;

    localparam int ACC_W = 24;
    localparam longint ACC_MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MINV = -(longint'(1) <<< (ACC_W-1));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [31:0]       pixel_i = '0;
    logic [31:0]       weight_i = '0;
    logic [15:0]       bias_i = '0;
    logic              relu_en = 1'b0;
    logic [ACC_W-1:0]  result_o;
    logic              out_valid;
    logic              sat_o;
    logic              busy_o;

    pwconv_pe_mlane #(.DATA_W(8), .FILTER_W(8), .BIAS_W(16), .LANES(4), .GUARD_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_last(in_last),
        .pixel_i(pixel_i), .weight_i(weight_i), .bias_i(bias_i), .relu_en(relu_en),
        .result_o(result_o), .out_valid(out_valid), .sat_o(sat_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    bit     mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint res;
        bit     sat;
        longint due;
    } exp_t;

    exp_t   expq[$];
    bit     m_open = 1'b0;
    longint m_acc = 0;
    bit     m_sat = 1'b0;
    longint last_res = 0;
    bit     last_sat = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        logic [7:0] la, lb, lc, ld;
        la = a[7:0]; lb = b[7:0]; lc = c[7:0]; ld = d[7:0];
        return {ld, lc, lb, la};
    endfunction

    function automatic longint dot(input logic [31:0] px, input logic [31:0] wt);
        longint s;
        logic signed [7:0] p, w;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            p = px[k*8 +: 8];
            w = wt[k*8 +: 8];
            s += longint'(p) * longint'(w);
        end
        return s;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > ACC_MAXV) return ACC_MAXV;
        if (v < ACC_MINV) return ACC_MINV;
        return v;
    endfunction

    task automatic model_clear();
        m_open = 1'b0;
        m_acc  = 0;
        m_sat  = 1'b0;
        expq.delete();
    endtask

    task automatic send_beat(input logic [31:0] px, input logic [31:0] wt, input int bias,
                             input bit last, input bit relu);
        longint a;
        exp_t   e;
        pixel_i = px; weight_i = wt; bias_i = bias[15:0];
        in_last = last; relu_en = relu; in_valid = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        a = m_open ? m_acc + dot(px, wt) : longint'(bias) + dot(px, wt);
        if (!m_open) m_sat = 1'b0;
        if (clamp(a) != a) m_sat = 1'b1;
        m_acc = clamp(a);
        if (last) begin
            e.res = (relu && m_acc < 0) ? 0 : m_acc;
            e.sat = m_sat;
            e.due = cyc + 3;
            expq.push_back(e);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
        check("busy_after_beat", busy_o, 1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush_cycle(input bit with_beat);
        flush = 1'b1;
        in_valid = with_beat; in_last = 1'b1;
        pixel_i = pack4(1, 1, 1, 1); weight_i = pack4(5, 5, 5, 5); bias_i = 16'd7;
        @(posedge clk); #1;
        model_clear();
        flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic rst_cycle();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        model_clear();
        last_res = 0; last_sat = 1'b0;
        rst = 1'b0;
        check("rst_result", longint'($signed(result_o)), 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sat", sat_o, 0);
        check("rst_busy", busy_o, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && expq.size() > 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("drain_pending", expq.size(), 0);
        idle(2);
        check("drain_busy", busy_o, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_v;
            exp_t e;
            while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
            exp_v = (expq.size() > 0) && (expq[0].due == cyc);
            check("out_valid", out_valid, exp_v);
            if (exp_v) begin
                e = expq.pop_front();
                check("result", longint'($signed(result_o)), e.res);
                check("sat", sat_o, e.sat);
                last_res = e.res;
                last_sat = e.sat;
            end else begin
                check("result_hold", longint'($signed(result_o)), last_res);
                check("sat_hold", sat_o, last_sat);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m128;
        int          len, gap;
        m128 = pack4(-128, -128, -128, -128);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_result", longint'($signed(result_o)), 0);
        check("init_out_valid", out_valid, 0);
        check("init_sat", sat_o, 0);
        check("init_busy", busy_o, 0);
        mon_en = 1'b1;

        // single beat: 4*(1*2) + 10
        send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 10, 1'b1, 1'b0);
        drain();
        check("t1_result", longint'($signed(result_o)), 18);
        check("t1_sat", sat_o, 0);

        // 3 beats of -10 plus bias 5, then the same with ReLU
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 3; b++)
                send_beat(pack4(1, 2, 3, 4), pack4(-1, -1, -1, -1), 5, b == 2, r == 1);
            drain();
            check("t2_result", longint'($signed(result_o)), r == 0 ? -25 : 0);
        end

        // back-to-back groups: A = 1+7+8, B = 0+3
        send_beat(pack4(7, 0, 0, 0), pack4(1, 1, 1, 1), 1, 1'b0, 1'b0);
        send_beat(pack4(2, 2, 2, 2), pack4(1, 1, 1, 1), 100, 1'b1, 1'b0);
        send_beat(pack4(3, 0, 0, 0), pack4(1, 1, 1, 1), 0, 1'b1, 1'b0);
        drain();
        check("t3_result_b", longint'($signed(result_o)), 3);

        // positive saturation over 2^GUARD_W*2 beats, then a clean group
        for (int b = 0; b < 128; b++) send_beat(m128, m128, 0, b == 127, 1'b0);
        drain();
        check("t4_sat_result", longint'($signed(result_o)), ACC_MAXV);
        check("t4_sat_flag", sat_o, 1);
        send_beat(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 10, 1'b1, 1'b0);
        drain();
        check("t4_clean_sat", sat_o, 0);

        // negative saturation
        for (int b = 0; b < 130; b++)
            send_beat(pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), -32768, b == 129, 1'b0);
        drain();
        check("t4_neg_sat", longint'($signed(result_o)), ACC_MINV);

        // flush mid-group together with a valid beat, then a 1-beat group
        send_beat(pack4(1, 1, 1, 1), pack4(3, 3, 3, 3), 9, 1'b0, 1'b0);
        send_beat(pack4(1, 1, 1, 1), pack4(3, 3, 3, 3), 9, 1'b0, 1'b0);
        flush_cycle(1'b1);
        idle(5);
        send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 2, 1'b1, 1'b0);
        drain();
        check("t5_result", longint'($signed(result_o)), 6);

        // flush catching a completed group still in the pipeline
        send_beat(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9), 0, 1'b1, 1'b0);
        idle(1);
        flush_cycle(1'b0);
        idle(4);
        check("t5_flush_keep", longint'($signed(result_o)), 6);

        // reset with beats in flight
        send_beat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 1, 1'b0, 1'b0);
        send_beat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 1, 1'b1, 1'b0);
        send_beat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 1, 1'b0, 1'b0);
        rst_cycle();
        idle(5);

        // idle gaps inside a group give the gap-free result: 3*10 + 3
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 3; b++) begin
                send_beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 3, b == 2, 1'b0);
                if (g == 0 && b < 2) idle(2);
            end
            drain();
            check("t6_gap_result", longint'($signed(result_o)), 33);
        end

        // randomized groups with gaps, ReLU and occasional flush
        for (int g = 0; g < 150; g++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                send_beat($urandom(), $urandom(), int'($urandom_range(0, 65535)) - 32768,
                          b == len - 1, $urandom_range(0, 1) == 1);
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                if (gap > 0) idle(gap);
            end
            if ($urandom_range(0, 19) == 0) flush_cycle($urandom_range(0, 1) == 1);
        end
        drain();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
